// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage that talks to a request/acknowledge instruction
// memory and presents one instruction at a time to the fetch/decode register.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   reset       : synchronous active-high reset
//   stallF      : hold request from the hazard unit
//   pcsrcE      : branch/jump redirect strobe from execute
//   pctargetE   : redirect target address (low two bits are forced to zero)
//   imem_req    : instruction memory request
//   imem_addr   : request address, held constant until the ack cycle
//   imem_ack    : memory response valid (imem_rdata valid in the same cycle)
//   imem_rdata  : fetched instruction word
//   instrF      : instruction presented downstream (NOP_INSTR when not valid)
//   pcF         : PC of instrF, or of the outstanding request when not valid
//   pcplus4F    : pcF + 4, modulo 2^32
//   validF      : instrF holds a real fetched instruction
//   fetch_busy  : waiting on memory (WAIT or DROP)
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stallF,
   input  logic        pcsrcE,
   input  logic [31:0] pctargetE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instrF,
   output logic [31:0] pcF,
   output logic [31:0] pcplus4F,
   output logic        validF,
   output logic        fetch_busy
);

   // WAIT : request outstanding, result wanted
   // READY: instruction buffered and presented downstream
   // DROP : request outstanding but stale, its data must be thrown away
   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_READY = 2'd1,
      ST_DROP  = 2'd2
   } state_t;

   state_t      state_r;
   state_t      next_state_s;
   logic [31:0] pc_r;
   logic [31:0] next_pc_s;
   logic [31:0] addr_r;
   logic [31:0] next_addr_s;
   logic [31:0] buf_r;
   logic [31:0] next_buf_s;
   logic [31:0] pcplus4_r;
   logic        valid_r;
   logic        busy_r;
   logic        req_r;
   logic [31:0] target_s;
   logic [31:0] pc_plus4_s;
   logic        unused_s;

   assign target_s   = {pctargetE[31:2], 2'b00};
   assign pc_plus4_s = pc_r + 32'd4;
   // Target alignment drops the low address bits on purpose.
   assign unused_s   = ^pctargetE[1:0];

   // Next-state and next-datapath decision; redirect outranks stall everywhere.
   // The buffer is kept at NOP_INSTR outside READY so instrF needs no mux.
   always_comb begin
      next_state_s = state_r;
      next_pc_s    = pc_r;
      next_addr_s  = addr_r;
      next_buf_s   = buf_r;
      case (state_r)
         ST_WAIT: begin
            if (pcsrcE) begin
               next_pc_s  = target_s;
               next_buf_s = NOP_INSTR;
               if (imem_ack) begin
                  // Response arrives with the redirect: drop it, reissue at target.
                  next_addr_s  = target_s;
                  next_state_s = ST_WAIT;
               end else begin
                  // Memory still owes us a word for the old address.
                  next_state_s = ST_DROP;
               end
            end else if (imem_ack) begin
               next_buf_s   = imem_rdata;
               next_state_s = ST_READY;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_READY: begin
            if (pcsrcE) begin
               next_pc_s    = target_s;
               next_addr_s  = target_s;
               next_buf_s   = NOP_INSTR;
               next_state_s = ST_WAIT;
            end else if (!stallF) begin
               next_pc_s    = pc_plus4_s;
               next_addr_s  = pc_plus4_s;
               next_buf_s   = NOP_INSTR;
               next_state_s = ST_WAIT;
            end else begin
               next_state_s = ST_READY;
            end
         end
         ST_DROP: begin
            if (imem_ack) begin
               // Stale word is discarded; issue the held (redirected) PC.
               if (pcsrcE) begin
                  next_pc_s   = target_s;
                  next_addr_s = target_s;
               end else begin
                  next_addr_s = pc_r;
               end
               next_state_s = ST_WAIT;
            end else if (pcsrcE) begin
               next_pc_s    = target_s;
               next_state_s = ST_DROP;
            end else begin
               next_state_s = ST_DROP;
            end
         end
         default: begin
            // Illegal encoding: recover by refetching the current PC.
            next_addr_s  = pc_r;
            next_buf_s   = NOP_INSTR;
            next_state_s = ST_WAIT;
         end
      endcase
   end

   // State register with all outputs registered from the next-state values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_WAIT;
         pc_r      <= RESET_PC;
         addr_r    <= RESET_PC;
         buf_r     <= NOP_INSTR;
         pcplus4_r <= RESET_PC + 32'd4;
         valid_r   <= 1'b0;
         busy_r    <= 1'b1;
         req_r     <= 1'b1;
      end else begin
         state_r   <= next_state_s;
         pc_r      <= next_pc_s;
         addr_r    <= next_addr_s;
         buf_r     <= next_buf_s;
         pcplus4_r <= next_pc_s + 32'd4;
         valid_r   <= (next_state_s == ST_READY);
         busy_r    <= (next_state_s != ST_READY);
         req_r     <= (next_state_s != ST_READY);
      end
   end

   assign imem_req   = req_r;
   assign imem_addr  = addr_r;
   assign instrF     = buf_r;
   assign pcF        = pc_r;
   assign pcplus4F   = pcplus4_r;
   assign validF     = valid_r;
   assign fetch_busy = busy_r;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed self-checking bench for fetch_stage. Each task drives one scenario
// and compares outputs against hand-computed values one time unit after the
// rising edge. Memory responses are driven by hand to model fixed latencies.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        stallF;
   logic        pcsrcE;
   logic [31:0] pctargetE;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instrF;
   logic [31:0] pcF;
   logic [31:0] pcplus4F;
   logic        validF;
   logic        fetch_busy;

   int checks = 0;
   int errors = 0;

   fetch_stage dut (
      .clk        (clk),
      .reset      (reset),
      .stallF     (stallF),
      .pcsrcE     (pcsrcE),
      .pctargetE  (pctargetE),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .instrF     (instrF),
      .pcF        (pcF),
      .pcplus4F   (pcplus4F),
      .validF     (validF),
      .fetch_busy (fetch_busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; stallF = 1'b1; pcsrcE = 1'b1; pctargetE = 32'h0000_0500;
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      step(); step();
      checks++; if (validF !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", validF); end
      checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%0h exp=1", fetch_busy); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got=%0h exp=1", imem_req); end
      checks++; if (pcF !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=00000000", pcF); end
      checks++; if (pcplus4F !== 32'h4) begin errors++; $display("FAIL reset_pcplus4 got=%h exp=00000004", pcplus4F); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=00000000", imem_addr); end
      checks++; if (instrF !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", instrF, NOP); end
      reset = 1'b0; stallF = 1'b0; pcsrcE = 1'b0; imem_ack = 1'b0;
   endtask

   task automatic test_sequential();
      // 1-cycle memory, no stall: addr 0 -> READY -> addr 4 -> READY.
      imem_ack = 1'b1; imem_rdata = 32'hA000_0000;
      step();
      checks++; if (validF !== 1'b1) begin errors++; $display("FAIL seq0_valid got=%0h exp=1", validF); end
      checks++; if (instrF !== 32'hA000_0000) begin errors++; $display("FAIL seq0_instr got=%h exp=a0000000", instrF); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq0_req got=%0h exp=0", imem_req); end
      checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL seq0_busy got=%0h exp=0", fetch_busy); end
      imem_ack = 1'b0;
      step();
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq1_addr got=%h exp=00000004", imem_addr); end
      checks++; if (validF !== 1'b0) begin errors++; $display("FAIL seq1_valid got=%0h exp=0", validF); end
      checks++; if (instrF !== NOP) begin errors++; $display("FAIL seq1_instr got=%h exp=%h", instrF, NOP); end
      checks++; if (pcF !== 32'h4) begin errors++; $display("FAIL seq1_pc got=%h exp=00000004", pcF); end
      imem_ack = 1'b1; imem_rdata = 32'hA000_0004;
      step();
      checks++; if (instrF !== 32'hA000_0004) begin errors++; $display("FAIL seq2_instr got=%h exp=a0000004", instrF); end
      checks++; if (pcplus4F !== 32'h8) begin errors++; $display("FAIL seq2_pcplus4 got=%h exp=00000008", pcplus4F); end
      imem_ack = 1'b0;
   endtask

   task automatic test_stall();
      // READY at 0x4 held for three stalled cycles, then released.
      stallF = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (instrF !== 32'hA000_0004 || pcF !== 32'h4 || validF !== 1'b1 || imem_req !== 1'b0) begin
            errors++; $display("FAIL stall_hold%0d got instr=%h pc=%h valid=%0h req=%0h exp instr=a0000004 pc=00000004 valid=1 req=0", i, instrF, pcF, validF, imem_req);
         end
      end
      stallF = 1'b0;
      step();
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_release_addr got=%h exp=00000008", imem_addr); end
      checks++; if (validF !== 1'b0) begin errors++; $display("FAIL stall_release_valid got=%0h exp=0", validF); end
   endtask

   task automatic test_drop();
      // 4-cycle latency on addr 0x8, redirect to 0x103 in the 2nd wait cycle.
      imem_ack = 1'b0;
      step();
      pcsrcE = 1'b1; pctargetE = 32'h0000_0103;
      step();
      pcsrcE = 1'b0;
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL drop_addr_hold got=%h exp=00000008", imem_addr); end
      checks++; if (pcF !== 32'h100) begin errors++; $display("FAIL drop_pc got=%h exp=00000100", pcF); end
      checks++; if (imem_req !== 1'b1 || fetch_busy !== 1'b1) begin errors++; $display("FAIL drop_req_busy got=%0h%0h exp=11", imem_req, fetch_busy); end
      step();
      checks++; if (imem_addr !== 32'h8 || validF !== 1'b0) begin errors++; $display("FAIL drop_cycle3 got addr=%h valid=%0h exp addr=00000008 valid=0", imem_addr, validF); end
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_0008;
      step();
      imem_ack = 1'b0;
      checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL drop_next_addr got=%h exp=00000100", imem_addr); end
      checks++; if (validF !== 1'b0 || instrF !== NOP) begin errors++; $display("FAIL drop_discard got valid=%0h instr=%h exp valid=0 instr=%h", validF, instrF, NOP); end
      checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL drop_wait_busy got=%0h exp=1", fetch_busy); end
      imem_ack = 1'b1; imem_rdata = 32'h0000_0111;
      step();
      imem_ack = 1'b0;
      checks++; if (instrF !== 32'h111 || pcF !== 32'h100 || validF !== 1'b1) begin errors++; $display("FAIL drop_fetch got instr=%h pc=%h valid=%0h exp instr=00000111 pc=00000100 valid=1", instrF, pcF, validF); end
   endtask

   task automatic test_redirect_ack();
      step();  // READY at 0x100 advances to WAIT at 0x104
      checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL rdack_addr got=%h exp=00000104", imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_0104; pcsrcE = 1'b1; pctargetE = 32'h0000_0200;
      step();
      pcsrcE = 1'b0; imem_ack = 1'b0;
      checks++; if (imem_addr !== 32'h200 || pcF !== 32'h200) begin errors++; $display("FAIL rdack_target got addr=%h pc=%h exp 00000200", imem_addr, pcF); end
      checks++; if (validF !== 1'b0 || instrF !== NOP) begin errors++; $display("FAIL rdack_discard got valid=%0h instr=%h exp valid=0 instr=%h", validF, instrF, NOP); end
      imem_ack = 1'b1; imem_rdata = 32'h0000_0222;
      step();
      imem_ack = 1'b0;
      checks++; if (instrF !== 32'h222 || validF !== 1'b1) begin errors++; $display("FAIL rdack_fetch got instr=%h valid=%0h exp 00000222 1", instrF, validF); end
   endtask

   task automatic test_wrap();
      // Redirect from READY to 0xFFFFFFFF aligns to 0xFFFFFFFC.
      pcsrcE = 1'b1; pctargetE = 32'hFFFF_FFFF; stallF = 1'b1;
      step();
      pcsrcE = 1'b0; stallF = 1'b0;
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h0000_0333;
      step();
      imem_ack = 1'b0;
      checks++; if (pcF !== 32'hFFFF_FFFC || pcplus4F !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4 got pc=%h pcplus4=%h exp fffffffc 00000000", pcF, pcplus4F); end
      step();
      checks++; if (imem_addr !== 32'h0 || pcF !== 32'h0 || pcplus4F !== 32'h4) begin errors++; $display("FAIL wrap_next got addr=%h pc=%h pcplus4=%h exp 0 0 4", imem_addr, pcF, pcplus4F); end
   endtask

   task automatic test_reset_drop();
      pcsrcE = 1'b1; pctargetE = 32'h0000_0300;
      step();
      pcsrcE = 1'b0;
      checks++; if (pcF !== 32'h300 || imem_addr !== 32'h0 || fetch_busy !== 1'b1) begin errors++; $display("FAIL rst_drop_enter got pc=%h addr=%h busy=%0h exp 00000300 00000000 1", pcF, imem_addr, fetch_busy); end
      reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0444;
      step();
      checks++; if (imem_addr !== 32'h0 || pcF !== 32'h0 || validF !== 1'b0 || fetch_busy !== 1'b1) begin errors++; $display("FAIL rst_drop_state got addr=%h pc=%h valid=%0h busy=%0h exp 0 0 0 1", imem_addr, pcF, validF, fetch_busy); end
      step();
      checks++; if (validF !== 1'b0 || instrF !== NOP) begin errors++; $display("FAIL rst_ack_ignored got valid=%0h instr=%h exp 0 %h", validF, instrF, NOP); end
      reset = 1'b0; imem_ack = 1'b0;
      step();
      checks++; if (validF !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL rst_wait got valid=%0h req=%0h exp 0 1", validF, imem_req); end
      imem_ack = 1'b1; imem_rdata = 32'h0000_0555;
      step();
      imem_ack = 1'b0;
      checks++; if (instrF !== 32'h555 || pcF !== 32'h0 || validF !== 1'b1) begin errors++; $display("FAIL rst_refetch got instr=%h pc=%h valid=%0h exp 00000555 0 1", instrF, pcF, validF); end
   endtask

   initial begin
      reset = 1'b1; stallF = 1'b0; pcsrcE = 1'b0; pctargetE = 32'h0;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      test_reset();
      test_sequential();
      test_stall();
      test_drop();
      test_redirect_ack();
      test_wrap();
      test_reset_drop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
